// File: rtl/rbs_pipe_if.sv
`default_nettype none
// ============================================================================
//  Module      : rbs_pipe_if
//  Description : Operand/result bundle for the pipelined ripple-borrow
//                subtractor. The master drives operands and the advance
//                enable; the slave (the subtractor) returns the result.
//                The ovf signal exists only when RBS_OVF_EN is defined.
//  Revision    : 1.0  initial release
// ============================================================================
interface rbs_pipe_if #(
    parameter int WIDTH = 4
);
    logic             en;
    logic             in_valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             Bin;
    logic             out_valid;
    logic [WIDTH-1:0] diff;
    logic             Bout;
`ifdef RBS_OVF_EN
    logic             ovf;
`endif

`ifdef RBS_OVF_EN
    modport master (
        output en, in_valid, a, b, Bin,
        input  out_valid, diff, Bout, ovf
    );
    modport slave (
        input  en, in_valid, a, b, Bin,
        output out_valid, diff, Bout, ovf
    );
`else
    modport master (
        output en, in_valid, a, b, Bin,
        input  out_valid, diff, Bout
    );
    modport slave (
        input  en, in_valid, a, b, Bin,
        output out_valid, diff, Bout
    );
`endif
endinterface
`default_nettype wire

// File: rtl/rbs_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : rbs_pipe
//  Description : Bit-level pipelined ripple-borrow subtractor computing
//                {Bout, diff} = a - b - Bin. One full-subtractor slice per
//                stage, one token per clock, global enable for stall.
//                Optional signed-overflow flag enabled by the macro
//                RBS_OVF_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module rbs_pipe #(
    parameter int WIDTH = 4            // operand width and stage count, >= 2
) (
    input  wire logic   clk,
    input  wire logic   rst,
    rbs_pipe_if.slave   bus
);

    // Stages 0..WIDTH-2 are internal registers; the last slice writes
    // straight into the output registers so latency equals WIDTH edges.
    localparam int NSTG = WIDTH - 1;

    // Stage k register layout:
    //   r_ad_q[k] : bits [k:0] completed difference, bits [WIDTH-1:k+1]
    //               still-unprocessed minuend bits
    //   r_b_q[k]  : bits [WIDTH-1:k+1] still-unprocessed subtrahend bits,
    //               processed bits are cleared
    //   r_bor_q[k]: borrow out of bit k
    logic [NSTG-1:0][WIDTH-1:0] r_ad_q,    r_ad_d;
    logic [NSTG-1:0][WIDTH-1:0] r_b_q,     r_b_d;
    logic [NSTG-1:0]            r_bor_q,   r_bor_d;
    logic [NSTG-1:0]            r_valid_q, r_valid_d;

    logic                       r_out_valid_q, r_out_valid_d;
    logic [WIDTH-1:0]           r_diff_q,      r_diff_d;
    logic                       r_bout_q,      r_bout_d;

    // Final slice results (bit WIDTH-1)
    logic [WIDTH-1:0]           w_fin_diff;
    logic                       w_fin_bout;

`ifdef RBS_OVF_EN
    logic                       r_ovf_q, r_ovf_d;
    logic                       w_fin_ovf;
`endif

    // One full-subtractor slice: resolves bit k of the working vector and
    // returns {borrow_out, working vector with bit k replaced by d[k]}.
    function automatic logic [WIDTH:0] f_slice(
        input logic [WIDTH-1:0] ad,
        input logic [WIDTH-1:0] bb,
        input logic             bin,
        input int               k
    );
        logic [WIDTH-1:0] nxt;
        logic             ak;
        logic             bk;
        logic             bo;
        ak     = ad[k];
        bk     = bb[k];
        nxt    = ad;
        nxt[k] = ak ^ bk ^ bin;
        bo     = (~ak & bk) | (~(ak ^ bk) & bin);
        return {bo, nxt};
    endfunction

    // Drops subtrahend bit k once consumed so stage data carries only the
    // bits still waiting to be processed.
    function automatic logic [WIDTH-1:0] f_clear(
        input logic [WIDTH-1:0] bb,
        input int               k
    );
        logic [WIDTH-1:0] m;
        m    = '0;
        m[k] = 1'b1;
        return bb & ~m;
    endfunction

    // Next-state for every slice: stage 0 from the ports, stage k from k-1.
    always_comb begin
        r_ad_d    = r_ad_q;
        r_b_d     = r_b_q;
        r_bor_d   = r_bor_q;
        r_valid_d = r_valid_q;

        {r_bor_d[0], r_ad_d[0]} = f_slice(bus.a, bus.b, bus.Bin, 0);
        r_b_d[0]                = f_clear(bus.b, 0);
        r_valid_d[0]            = bus.in_valid;

        for (int k = 1; k < NSTG; k++) begin
            {r_bor_d[k], r_ad_d[k]} = f_slice(r_ad_q[k-1], r_b_q[k-1],
                                              r_bor_q[k-1], k);
            r_b_d[k]                = f_clear(r_b_q[k-1], k);
            r_valid_d[k]            = r_valid_q[k-1];
        end
    end

    // Last slice: resolves the top bit from the final internal stage.
    always_comb begin
        {w_fin_bout, w_fin_diff} = f_slice(r_ad_q[NSTG-1], r_b_q[NSTG-1],
                                           r_bor_q[NSTG-1], WIDTH-1);
    end

`ifdef RBS_OVF_EN
    // Signed overflow: borrow into the sign bit differs from borrow out.
    always_comb begin
        w_fin_ovf = r_bor_q[NSTG-1] ^ w_fin_bout;
    end
`endif

    // Output registers capture only valid tokens; bubbles leave them holding.
    always_comb begin
        r_out_valid_d = r_valid_q[NSTG-1];
        r_diff_d      = r_diff_q;
        r_bout_d      = r_bout_q;
`ifdef RBS_OVF_EN
        r_ovf_d       = r_ovf_q;
`endif
        if (r_valid_q[NSTG-1]) begin
            r_diff_d = w_fin_diff;
            r_bout_d = w_fin_bout;
`ifdef RBS_OVF_EN
            r_ovf_d  = w_fin_ovf;
`endif
        end
    end

    // Pipeline and output registers: async clear, advance only when enabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ad_q        <= '0;
            r_b_q         <= '0;
            r_bor_q       <= '0;
            r_valid_q     <= '0;
            r_out_valid_q <= 1'b0;
            r_diff_q      <= '0;
            r_bout_q      <= 1'b0;
`ifdef RBS_OVF_EN
            r_ovf_q       <= 1'b0;
`endif
        end else if (bus.en) begin
            r_ad_q        <= r_ad_d;
            r_b_q         <= r_b_d;
            r_bor_q       <= r_bor_d;
            r_valid_q     <= r_valid_d;
            r_out_valid_q <= r_out_valid_d;
            r_diff_q      <= r_diff_d;
            r_bout_q      <= r_bout_d;
`ifdef RBS_OVF_EN
            r_ovf_q       <= r_ovf_d;
`endif
        end
    end

    assign bus.out_valid = r_out_valid_q;
    assign bus.diff      = r_diff_q;
    assign bus.Bout      = r_bout_q;
`ifdef RBS_OVF_EN
    assign bus.ovf       = r_ovf_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rbs_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rbs_pipe
//  Description : Self-checking bench for rbs_pipe (WIDTH=4). The driver
//                queues the expected result and the enabled-edge index at
//                which it must appear; a monitor pops and compares whenever
//                a fresh result is presented, and checks that outputs hold
//                otherwise.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_rbs_pipe;

    localparam int W = 4;

    typedef struct {
        logic [W-1:0] d;
        logic         bo;
        logic         ov;
        int           idx;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    rbs_pipe_if #(.WIDTH(W)) ifc ();

    rbs_pipe #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    always #5 clk = ~clk;

    exp_t          q[$];
    int            n_checks = 0;
    int            n_fail   = 0;
    int            en_edges = 0;
    logic          last_en  = 1'b0;
    logic [W-1:0]  mon_last_diff = '0;
    logic          mon_last_bo   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic [W-1:0] d, input logic bo, input logic ov);
        exp_t x;
        x.d   = d;
        x.bo  = bo;
        x.ov  = ov;
        x.idx = 0;
        return x;
    endfunction

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
        exp_t       x;
        logic [W:0] r;
        int         s;
        r    = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};
        s    = int'($signed(a)) - int'($signed(b)) - int'(bin);
        x.d  = r[W-1:0];
        x.bo = r[W];
        x.ov = (s < -(2 ** (W-1))) || (s > (2 ** (W-1)) - 1);
        x.idx = 0;
        return x;
    endfunction

    // Drive one cycle of stimulus (called at a negedge); queue expectation.
    task automatic step(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic bin, input logic e, input exp_t x);
        exp_t y;
        ifc.in_valid = v;
        ifc.a        = a;
        ifc.b        = b;
        ifc.Bin      = bin;
        ifc.en       = e;
        if (v && e) begin
            y     = x;
            y.idx = en_edges + W;
            q.push_back(y);
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, 1'b1, mk('0, 1'b0, 1'b0));
    endtask

    // Track which edges actually advanced the pipeline.
    always @(posedge clk) begin
        last_en <= ifc.en && !rst;
        if (ifc.en && !rst) en_edges <= en_edges + 1;
    end

    // Monitor: compare fresh results against the scoreboard, else check hold.
    always @(negedge clk) begin
        exp_t x;
        if (!rst) begin
            if (ifc.out_valid && last_en) begin
                if (q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_token: got diff %0h Bout %0b expected no token at %0t",
                             ifc.diff, ifc.Bout, $time);
                end else begin
                    x = q.pop_front();
                    chk("diff", 32'(ifc.diff), 32'(x.d));
                    chk("Bout", 32'(ifc.Bout), 32'(x.bo));
`ifdef RBS_OVF_EN
                    chk("ovf", 32'(ifc.ovf), 32'(x.ov));
`endif
                    chk("latency_edge", 32'(en_edges), 32'(x.idx));
                end
                mon_last_diff = ifc.diff;
                mon_last_bo   = ifc.Bout;
            end else begin
                chk("hold_diff", 32'(ifc.diff), 32'(mon_last_diff));
                chk("hold_Bout", 32'(ifc.Bout), 32'(mon_last_bo));
            end
        end
    end

    // Drain the scoreboard within a bounded number of cycles.
    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 20) begin
            idle(1);
            n++;
        end
        n_checks++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
            q.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rbin;

        ifc.en = 1'b0; ifc.in_valid = 1'b0; ifc.a = '0; ifc.b = '0; ifc.Bin = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("reset_out_valid", 32'(ifc.out_valid), 0);
        chk("reset_diff", 32'(ifc.diff), 0);
        chk("reset_Bout", 32'(ifc.Bout), 0);
`ifdef RBS_OVF_EN
        chk("reset_ovf", 32'(ifc.ovf), 0);
`endif
        rst = 1'b0;

        // Wrap: 0 - 0 - 1
        step(1'b1, 4'b0000, 4'b0000, 1'b1, 1'b1, mk(4'b1111, 1'b1, 1'b0));
        idle(7);

        // Back-to-back tokens
        step(1'b1, 4'b0101, 4'b0011, 1'b0, 1'b1, mk(4'b0010, 1'b0, 1'b0));
        step(1'b1, 4'b0011, 4'b0010, 1'b1, 1'b1, mk(4'b0000, 1'b0, 1'b0));
        step(1'b1, 4'b1111, 4'b0001, 1'b1, 1'b1, mk(4'b1101, 1'b0, 1'b0));
        idle(7);

        // Stall: en low for two cycles after the second enabled edge
        step(1'b1, 4'b0001, 4'b0010, 1'b0, 1'b1, mk(4'b1111, 1'b1, 1'b0));
        step(1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, mk('0, 1'b0, 1'b0));
        step(1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, mk('0, 1'b0, 1'b0));
        step(1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, mk('0, 1'b0, 1'b0));
        idle(6);

        // Overflow vectors
        step(1'b1, 4'b1000, 4'b0001, 1'b0, 1'b1, mk(4'b0111, 1'b0, 1'b1));
        step(1'b1, 4'b0111, 4'b1111, 1'b0, 1'b1, mk(4'b1000, 1'b1, 1'b1));
        step(1'b1, 4'b0101, 4'b0011, 1'b0, 1'b1, mk(4'b0010, 1'b0, 1'b0));
        drain();

        // Asynchronous reset with two tokens in flight
        step(1'b1, 4'b1010, 4'b0011, 1'b0, 1'b1, mk(4'b0111, 1'b0, 1'b0));
        step(1'b1, 4'b0100, 4'b0110, 1'b1, 1'b1, mk(4'b1101, 1'b1, 1'b0));
        ifc.in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("async_rst_out_valid", 32'(ifc.out_valid), 0);
        chk("async_rst_diff", 32'(ifc.diff), 0);
        chk("async_rst_Bout", 32'(ifc.Bout), 0);
        q.delete();
        mon_last_diff = '0;
        mon_last_bo   = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, mk('0, 1'b0, 1'b0));
            chk("post_rst_no_token", 32'(ifc.out_valid), 0);
        end

        // Alternating valid/bubble with random operands
        for (int i = 0; i < 200; i++) begin
            ra   = W'($urandom_range(0, 15));
            rb   = W'($urandom_range(0, 15));
            rbin = 1'($urandom_range(0, 1));
            step((i % 2) == 0, ra, rb, rbin, 1'b1, model(ra, rb, rbin));
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rbs_pipe.md
# rbs_pipe

Bit-level pipelined ripple-borrow subtractor: computes a − b − Bin with one full-subtractor slice per pipeline stage, so throughput is one operation per clock at any WIDTH. It is the inverse-operation partner of the team's pipelined ripple-carry adder and uses the same operand/flag port style, so the two can be cross-checked (a + b then − b) in the datapath and benches. A valid bit travels with each token and a global enable provides stall.

## Interface
- WIDTH, 4: operand and result width; also the number of pipeline stages (≥ 2).
- clk  input  1  rising-edge clock for all state.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  pipeline advance enable; 0 freezes every register.
- in_valid  input  1  a/b/Bin are a valid operation this cycle.
- a  input  WIDTH  minuend.
- b  input  WIDTH  subtrahend.
- Bin  input  1  borrow in.
- out_valid  output  1  diff/Bout hold a newly completed result this cycle.
- diff  output  WIDTH  difference, mod 2^WIDTH.
- Bout  output  1  borrow out (1 when a < b + Bin, unsigned).
- ovf  output  1  signed overflow; present only with RBS_OVF_EN.

## Operation
- Result: {Bout, diff} = {0,a} − {0,b} − Bin, computed as (WIDTH+1)-bit two's complement; Bout is the inverted carry.
- Stage k (0..WIDTH−1) resolves bit k only: d[k] = a[k]^b[k]^bin_k, bout_k = (~a[k]&b[k]) | (~(a[k]^b[k])&bin_k); bin_0 = Bin.
- Each stage register carries: valid bit, borrow out of bit k, completed diff bits [k:0], unprocessed a/b bits [WIDTH−1:k+1]. No separate skew/deskew banks outside the stage registers.
- Stage 0 samples a, b, Bin, in_valid when en=1; stage k samples stage k−1 when en=1.
- Output registers (diff, Bout, ovf) load only when the final stage's token is valid and en=1; otherwise they hold the last valid result. out_valid is the final stage's valid bit and is registered.
- in_valid=0 inserts a bubble; bubbles propagate and never change diff/Bout.
- en=0: all stage, valid and output registers hold; out_valid keeps its value (consumer must qualify with en if it counts tokens).
- No backpressure beyond en; no token is ever dropped or duplicated while en=1.

## Timing
- Latency: token sampled at enabled edge N appears with out_valid=1 after enabled edge N+WIDTH−1 (WIDTH enabled edges total, including the sampling edge); disabled cycles add 1 each.
- Throughput: 1 token/cycle; back-to-back tokens exit on consecutive cycles in order.
- Reset values: out_valid=0, diff=0, Bout=0, ovf=0; all stage valid bits 0, all stage data 0.
- Reset mid-operation: asserting rst clears all in-flight tokens immediately (asynchronous); none emerge after release. First enabled edge after release may sample a new token.
- rst and en simultaneous: rst wins.
- Wrap: diff wraps mod 2^WIDTH; e.g. 0 − 0 − 1 = all-ones with Bout=1.

## Configuration
- RBS_OVF_EN defined: ovf port exists; ovf = borrow into bit WIDTH−1 XOR borrow out of bit WIDTH−1 (signed result outside [−2^(WIDTH−1), 2^(WIDTH−1)−1]); loaded with diff, same latency, reset 0.
- RBS_OVF_EN undefined: ovf port and all overflow logic absent; other behaviour identical.

## Test plan
- Reset, en=1, a=0000 b=0000 Bin=1 one cycle -> after 4 edges out_valid=1 for 1 cycle, diff=1111, Bout=1; then out_valid=0, diff/Bout hold.
- a=0101 b=0011 Bin=0, then a=0011 b=0010 Bin=1, then a=1111 b=0001 Bin=1 on consecutive cycles -> three consecutive out_valid cycles: 0010/0, 0000/0, 1101/0.
- Token a=0001 b=0010 Bin=0, en=0 for 2 cycles after 2nd edge -> out_valid at 6 cycles, diff=1111, Bout=1; registers frozen while en=0.
- Two tokens in flight, rst pulsed for 1 cycle -> out_valid, diff, Bout go 0 asynchronously; no out_valid for the next 6 cycles with in_valid=0.
- Alternating in_valid 1/0 with random operands for 200 cycles -> every result matches a−b−Bin in order; diff unchanged on bubble cycles.
- RBS_OVF_EN: a=1000 b=0001 Bin=0 -> diff=0111 Bout=0 ovf=1; a=0111 b=1111 Bin=0 -> diff=1000 Bout=1 ovf=1; a=0101 b=0011 -> ovf=0.
